// File: rtl/zion_rr_arb_reg_ctrl_pkg.sv
// Shared types for the round-robin arbiter with a single registered output slot.
package zion_rr_arb_reg_ctrl_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_st_e;

endpackage

// File: rtl/zion_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo NUM_REQ.
// NUM_REQ need not be a power of two; the wrap is a compare-and-subtract.
module zion_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);

  localparam logic [ID_W:0] N_L = (ID_W+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_win;
  logic [ID_W:0]        w_off;
  logic [ID_W:0]        w_sum;
  logic                 w_found;

  // Rotating the doubled vector by ptr puts the search start at bit 0.
  always_comb begin
    w_dbl   = {req, req} >> ptr;
    w_win   = w_dbl[NUM_REQ-1:0];
    w_off   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_win[i]) begin
        w_found = 1'b1;
        w_off   = (ID_W+1)'(i);
      end
    end
    w_sum = {1'b0, ptr} + w_off;
    if (w_sum >= N_L) begin
      w_sum = w_sum - N_L;
    end
  end

  assign any    = |req;
  assign gnt_id = w_sum[ID_W-1:0];
  assign gnt    = any ? (NUM_REQ'(1) << gnt_id) : '0;

endmodule

// File: rtl/zion_rr_arb_reg_ctrl.sv
// Round-robin arbiter feeding one registered output slot; refills in the same cycle it drains.
// One cycle accept-to-oVld; iRdy is a combinational function of iVld, slot state and oRdy.
`define ZION_RR_ARB_REG_CTRL(inst_n, clk_s, rst_s, ivld_s, irdy_s, idat_s, ovld_s, ordy_s, odat_s, gnt_s) \
  zion_rr_arb_reg_ctrl #(.NUM_REQ($bits(ivld_s)), .WIDTH($bits(odat_s))) inst_n ( \
    .clk(clk_s), .rst(rst_s), .iVld(ivld_s), .iRdy(irdy_s), .iDat(idat_s), \
    .oVld(ovld_s), .oRdy(ordy_s), .oDat(odat_s), .oGntId(gnt_s))

module zion_rr_arb_reg_ctrl
  import zion_rr_arb_reg_ctrl_pkg::*;
#(
  parameter  int               NUM_REQ  = 4,
  parameter  int               WIDTH    = 8,
  parameter  logic [WIDTH-1:0] INI_DATA = '0,
  localparam int               ID_W     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       iVld,
  output logic [NUM_REQ-1:0]       iRdy,
  input  logic [NUM_REQ*WIDTH-1:0] iDat,
  output logic                     oVld,
  input  logic                     oRdy,
  output logic [WIDTH-1:0]         oDat,
  output logic [ID_W-1:0]          oGntId
);

  if (NUM_REQ < 2 || WIDTH < 1) begin : g_param_chk
`ifdef CHECK_ERR_EXIT
    $fatal(1, "zion_rr_arb_reg_ctrl: NUM_REQ must be >= 2 and WIDTH >= 1");
`else
    $error("zion_rr_arb_reg_ctrl: NUM_REQ must be >= 2 and WIDTH >= 1");
`endif
  end

  slot_st_e           r_st;
  slot_st_e           w_st_nxt;
  logic [WIDTH-1:0]   r_dat;
  logic [ID_W-1:0]    r_gnt_id;
  logic [ID_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_pick_id;
  logic               w_any;
  logic               w_load_en;
  logic               w_accept;
  logic [WIDTH-1:0]   w_sel_dat;

  zion_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (iVld),
    .ptr    (r_ptr),
    .gnt    (w_gnt),
    .gnt_id (w_pick_id),
    .any    (w_any)
  );

  assign oVld      = (r_st == SLOT_FULL);
  assign w_load_en = ~oVld | oRdy;
  // Ready is withheld during reset so nothing is handed over while the slot is being cleared.
  assign iRdy      = (w_load_en && !rst) ? w_gnt : '0;
  assign w_accept  = |(iVld & iRdy);
  assign oDat      = r_dat;
  assign oGntId    = r_gnt_id;

  always_comb begin
    w_sel_dat = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt[k]) begin
        w_sel_dat = iDat[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      SLOT_EMPTY: if (w_accept) w_st_nxt = SLOT_FULL;
      SLOT_FULL:  if (oRdy && !w_accept) w_st_nxt = SLOT_EMPTY;
      default:    w_st_nxt = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st     <= SLOT_EMPTY;
      r_dat    <= INI_DATA;
      r_gnt_id <= '0;
      r_ptr    <= '0;
    end else begin
      r_st <= w_st_nxt;
      if (w_accept) begin
        r_dat    <= w_sel_dat;
        r_gnt_id <= w_pick_id;
        r_ptr    <= (w_pick_id == ID_W'(NUM_REQ-1)) ? '0 : w_pick_id + ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_zion_rr_arb_reg_ctrl.sv
// Bench: directed vector table on a 4-requester instance, then random traffic on 3- and 5-requester
// instances compared against a queue-free behavioural model of the round-robin rules.
module tb_zion_rr_arb_reg_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- 4-requester instance, directed ----------------
  logic        rst4;
  logic [3:0]  vld4;
  logic [3:0]  irdy4;
  logic [31:0] dat4;
  logic        ovld4;
  logic        ordy4;
  logic [7:0]  odat4;
  logic [1:0]  gid4;

  zion_rr_arb_reg_ctrl #(.NUM_REQ(4), .WIDTH(8), .INI_DATA(8'h00)) dut4 (
    .clk(clk), .rst(rst4), .iVld(vld4), .iRdy(irdy4), .iDat(dat4),
    .oVld(ovld4), .oRdy(ordy4), .oDat(odat4), .oGntId(gid4)
  );

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] irdy;
    logic       ovld;
    logic [1:0] gid;
    logic [7:0] dat;
  } vec_t;

  function automatic vec_t mk(logic r, logic [3:0] v, logic o, logic [3:0] ir, logic ov,
                              logic [1:0] g, logic [7:0] d);
    vec_t t;
    t.rst = r; t.vld = v; t.ordy = o; t.irdy = ir; t.ovld = ov; t.gid = g; t.dat = d;
    return t;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    rst4 = v.rst; vld4 = v.vld; ordy4 = v.ordy;
    #1;
    chk({tag, "_irdy"}, 64'(irdy4), 64'(v.irdy));
    @(posedge clk);
    #1;
    chk({tag, "_ovld"}, 64'(ovld4), 64'(v.ovld));
    if (v.ovld || v.rst) begin
      chk({tag, "_gid"}, 64'(gid4), 64'(v.gid));
      chk({tag, "_dat"}, 64'(odat4), 64'(v.dat));
    end
  endtask

  // ---------------- 3- and 5-requester instances, random ----------------
  logic        rst_r;
  logic [2:0]  vld3, irdy3;
  logic [23:0] dat3;
  logic        ovld3, ordy3;
  logic [7:0]  odat3;
  logic [1:0]  gid3;
  logic [4:0]  vld5, irdy5;
  logic [39:0] dat5;
  logic        ovld5, ordy5;
  logic [7:0]  odat5;
  logic [2:0]  gid5;

  zion_rr_arb_reg_ctrl #(.NUM_REQ(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst(rst_r), .iVld(vld3), .iRdy(irdy3), .iDat(dat3),
    .oVld(ovld3), .oRdy(ordy3), .oDat(odat3), .oGntId(gid3)
  );

  zion_rr_arb_reg_ctrl #(.NUM_REQ(5), .WIDTH(8)) dut5 (
    .clk(clk), .rst(rst_r), .iVld(vld5), .iRdy(irdy5), .iDat(dat5),
    .oVld(ovld5), .oRdy(ordy5), .oDat(odat5), .oGntId(gid5)
  );

  int         m_ptr [2];
  bit         m_vld [2];
  logic [7:0] m_dat [2];
  int         m_gid [2];
  int         m_wait[2][5];
  int         m_acc [2];
  int         m_drn [2];

  task automatic step_model(input int k, input logic [4:0] vld, input logic [39:0] dat,
                            input logic ordy, input logic [4:0] irdy, input logic ovld,
                            input logic [7:0] odat, input logic [2:0] gid);
    int n;
    int pick;
    bit any;
    bit acc;
    logic [4:0] exp_irdy;
    n    = (k == 0) ? 3 : 5;
    any  = 1'b0;
    pick = 0;
    for (int o = 0; o < n; o++) begin
      int j;
      j = (m_ptr[k] + o) % n;
      if (!any && vld[j]) begin
        any  = 1'b1;
        pick = j;
      end
    end
    acc      = (!m_vld[k] || ordy) && any;
    exp_irdy = acc ? (5'd1 << pick) : 5'd0;
    chk($sformatf("rnd%0d_irdy", n), 64'(irdy), 64'(exp_irdy));
    chk($sformatf("rnd%0d_onehot", n), 64'($onehot0(irdy)), 64'd1);
    chk($sformatf("rnd%0d_ovld", n), 64'(ovld), 64'(m_vld[k]));
    if (m_vld[k]) begin
      chk($sformatf("rnd%0d_dat", n), 64'(odat), 64'(m_dat[k]));
      chk($sformatf("rnd%0d_gid", n), 64'(gid), 64'(m_gid[k]));
    end
    for (int j = 0; j < n; j++) begin
      if (acc && pick == j) begin
        chk($sformatf("rnd%0d_fair%0d", n, j), 64'(m_wait[k][j] <= n - 1), 64'd1);
        m_wait[k][j] = 0;
      end else if (!vld[j]) begin
        m_wait[k][j] = 0;
      end else if (acc) begin
        m_wait[k][j]++;
      end
    end
    if (m_vld[k] && ordy) m_drn[k]++;
    if (acc) begin
      m_acc[k]++;
      m_dat[k] = dat[pick*8 +: 8];
      m_gid[k] = pick;
      m_vld[k] = 1'b1;
      m_ptr[k] = (pick + 1) % n;
    end else if (m_vld[k] && ordy) begin
      m_vld[k] = 1'b0;
    end
  endtask

  vec_t tv[$];

  initial begin
    rst4 = 1'b1; vld4 = 4'hF; ordy4 = 1'b1; dat4 = 32'hD3C2B1A0;
    rst_r = 1'b1; vld3 = '0; vld5 = '0; dat3 = '0; dat5 = '0; ordy3 = 1'b0; ordy5 = 1'b0;

    // rst, vld, ordy | irdy during cycle | ovld, gid, dat after the edge
    for (int i = 0; i < 3; i++) tv.push_back(mk(1, 4'hF, 1, 4'h0, 0, 2'd0, 8'h00));
    tv.push_back(mk(0, 4'hF, 1, 4'h1, 1, 2'd0, 8'hA0));
    tv.push_back(mk(0, 4'hF, 1, 4'h2, 1, 2'd1, 8'hB1));
    tv.push_back(mk(0, 4'hF, 1, 4'h4, 1, 2'd2, 8'hC2));
    tv.push_back(mk(0, 4'hF, 1, 4'h8, 1, 2'd3, 8'hD3));
    tv.push_back(mk(0, 4'hF, 1, 4'h1, 1, 2'd0, 8'hA0));
    for (int i = 0; i < 5; i++) tv.push_back(mk(0, 4'hF, 0, 4'h0, 1, 2'd0, 8'hA0));
    tv.push_back(mk(0, 4'hF, 1, 4'h2, 1, 2'd1, 8'hB1));
    tv.push_back(mk(0, 4'h8, 1, 4'h8, 1, 2'd3, 8'hD3));
    tv.push_back(mk(0, 4'h1, 1, 4'h1, 1, 2'd0, 8'hA0));
    tv.push_back(mk(0, 4'h1, 1, 4'h1, 1, 2'd0, 8'hA0));
    tv.push_back(mk(0, 4'h0, 1, 4'h0, 0, 2'd0, 8'h00));
    tv.push_back(mk(0, 4'h6, 0, 4'h2, 1, 2'd1, 8'hB1));
    tv.push_back(mk(0, 4'h6, 0, 4'h0, 1, 2'd1, 8'hB1));

    for (int i = 0; i < tv.size(); i++) run_vec(tv[i], $sformatf("vec%0d", i));

    // Reset while FULL and stalled: pending B1 is dropped and the pointer returns to 0,
    // so requesters {3,0} resolve to 0 (a stale pointer of 2 would pick 3).
    run_vec(mk(1, 4'hF, 0, 4'h0, 0, 2'd0, 8'h00), "rstfull");
    run_vec(mk(0, 4'h9, 0, 4'h1, 1, 2'd0, 8'hA0), "postrst");
    run_vec(mk(0, 4'h9, 1, 4'h8, 1, 2'd3, 8'hD3), "postrst_next");

    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0; m_vld[k] = 1'b0; m_dat[k] = '0; m_gid[k] = 0; m_acc[k] = 0; m_drn[k] = 0;
      for (int j = 0; j < 5; j++) m_wait[k][j] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rnd3_rst_ovld", 64'(ovld3), 64'd0);
    chk("rnd5_rst_ovld", 64'(ovld5), 64'd0);

    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      rst_r = 1'b0;
      vld3  = 3'($urandom) | 3'($urandom);
      vld5  = 5'($urandom) | 5'($urandom);
      dat3  = 24'($urandom);
      dat5  = {8'($urandom), 32'($urandom)};
      ordy3 = ($urandom_range(0, 9) < 7);
      ordy5 = ($urandom_range(0, 9) < 6);
      #1;
      step_model(0, {2'b0, vld3}, {16'b0, dat3}, ordy3, {2'b0, irdy3}, ovld3, odat3, {1'b0, gid3});
      step_model(1, vld5, dat5, ordy5, irdy5, ovld5, odat5, gid5);
    end
    chk("rnd3_traffic", 64'(m_acc[0] > 1000), 64'd1);
    chk("rnd5_traffic", 64'(m_acc[1] > 1000), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
